// File: rtl/rca_8_pkg.sv
// rca_8_pkg: shared constants for the ripple-carry adder family.
//
// Carries only the operand width so that wrappers cascading several rca_8
// instances through cin/cout can size their buses consistently.
package rca_8_pkg;

    // Operand width of one rca_8 slice.
    localparam int unsigned ADD_W = 8;

endpackage : rca_8_pkg

// File: rtl/rca_8_full_adder.sv
// full_adder: single-bit full adder, purely combinational.
//
// Ports:
//   a   input   addend bit
//   b   input   addend bit
//   ci  input   carry-in
//   s   output  sum bit        (a ^ b ^ ci)
//   co  output  carry-out      (a & b | ci & (a ^ b))
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;  // propagate: carry-in passes through when the operand bits differ

    always_comb begin
        p  = a ^ b;
        s  = p ^ ci;
        co = (a & b) | (ci & p);
    end

endmodule : full_adder

// File: rtl/rca_8.sv
// rca_8: 8-bit unsigned ripple-carry adder with registered outputs.
//
// Eight full_adder cells form a strict bit 0 -> bit 7 carry chain; the 8-bit
// sum and the carry out of bit 7 are captured on the rising clock edge.
// {cout, S} = A + B + cin (0..511), valid one cycle after the operands.
//
// Ports:
//   clk   input      system clock, rising edge
//   rst   input      synchronous active-high reset; clears S and cout
//   A     input  8   addend, unsigned
//   B     input  8   addend, unsigned
//   cin   input  1   carry-in into bit 0
//   S     output 8   registered sum
//   cout  output 1   registered carry-out
module rca_8
    import rca_8_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [ADD_W-1:0] A,
    input  logic [ADD_W-1:0] B,
    input  logic             cin,
    output logic [ADD_W-1:0] S,
    output logic             cout
);

    // c[i] is the carry into bit i; c[ADD_W] is the carry out of the top bit.
    logic [ADD_W:0]   c;
    logic [ADD_W-1:0] sum;

    logic [ADD_W-1:0] s_q;
    logic             cout_q;

    assign c[0] = cin;

    // No lookahead: each stage waits on the previous stage's carry.
    for (genvar i = 0; i < ADD_W; i++) begin : g_fa
        full_adder u_fa (
            .a  (A[i]),
            .b  (B[i]),
            .ci (c[i]),
            .s  (sum[i]),
            .co (c[i+1])
        );
    end

    // Reset takes priority over the result computed for the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q    <= '0;
            cout_q <= 1'b0;
        end else begin
            s_q    <= sum;
            cout_q <= c[ADD_W];
        end
    end

    assign S    = s_q;
    assign cout = cout_q;

endmodule : rca_8

// File: tb/tb_rca_8.sv
// tb_rca_8: self-checking bench for rca_8 using directed vectors with
// hand-computed results plus a randomized sweep against A + B + cin.
module tb_rca_8;

    logic       clk;
    logic       rst;
    logic [7:0] A;
    logic [7:0] B;
    logic       cin;
    logic [7:0] S;
    logic       cout;

    int n_cmp;
    int n_bad;

    rca_8 dut (
        .clk  (clk),
        .rst  (rst),
        .A    (A),
        .B    (B),
        .cin  (cin),
        .S    (S),
        .cout (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Time limit: the bench must never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running, need finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got {cout,S}=%0d (cout=%0b S=%0d), need %0d (cout=%0b S=%0d)",
                     tag, got, got[8], got[7:0], exp, exp[8], exp[7:0]);
        end
    endtask

    // Drive operands, take one edge, sample #1 later and check.
    task automatic apply(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic ci, input logic [8:0] exp);
        A   = a;
        B   = b;
        cin = ci;
        @(posedge clk);
        #1;
        check_eq(tag, {cout, S}, exp);
    endtask

    logic [15:0] wide;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic        rc;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        A     = 8'd255;
        B     = 8'd255;
        cin   = 1'b1;

        // Reset held for two edges with a maximal operand set present.
        @(posedge clk); #1;
        check_eq("reset_edge1", {cout, S}, 9'd0);
        @(posedge clk); #1;
        check_eq("reset_edge2", {cout, S}, 9'd0);
        rst = 1'b0;
        apply("release_255_255_1", 8'd255, 8'd255, 1'b1, 9'd511);

        apply("120_240_0", 8'd120, 8'd240, 1'b0, {1'b1, 8'd104});

        // 256 in a wider context truncates to 0 on B.
        wide = 16'd256;
        apply("169_trunc256_1", 8'd169, wide[7:0], 1'b1, {1'b0, 8'd170});

        apply("53_250_0", 8'd53, 8'd250, 1'b0, {1'b1, 8'd47});
        apply("1_50_1", 8'd1, 8'd50, 1'b1, {1'b0, 8'd52});
        apply("50_100_0", 8'd50, 8'd100, 1'b0, {1'b0, 8'd150});
        apply("ripple_255_0_1", 8'd255, 8'd0, 1'b1, {1'b1, 8'd0});
        apply("0_0_0", 8'd0, 8'd0, 1'b0, 9'd0);
        apply("0_0_1", 8'd0, 8'd0, 1'b1, 9'd1);
        apply("170_85_0", 8'd170, 8'd85, 1'b0, {1'b0, 8'd255});
        apply("128_128_0", 8'd128, 8'd128, 1'b0, {1'b1, 8'd0});
        apply("15_1_0", 8'd15, 8'd1, 1'b0, {1'b0, 8'd16});

        // Inputs changing between edges must not disturb the held result.
        apply("hold_before", 8'd100, 8'd27, 1'b1, {1'b0, 8'd128});
        #2;
        A   = 8'd255;
        B   = 8'd255;
        cin = 1'b1;
        #2;
        check_eq("hold_mid_cycle", {cout, S}, {1'b0, 8'd128});

        // Reset mid-stream discards the in-flight result.
        A   = 8'd200;
        B   = 8'd200;
        cin = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("reset_midstream", {cout, S}, 9'd0);
        rst = 1'b0;
        apply("after_midreset", 8'd200, 8'd200, 1'b0, {1'b1, 8'd144});

        // Back-to-back random operands, one new set per cycle.
        for (int i = 0; i < 400; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            apply("random", ra, rb, rc, 9'(ra) + 9'(rb) + 9'(rc));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_rca_8
